// File: rtl/rr_arbiter8_pkg.sv
// Shared types and constants for the eight-way round-robin arbiter.
// Optional hold timeout is enabled with `define RR_ARBITER8_TIMEOUT_EN.
package rr_arbiter8_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter8_pick.sv
// Combinational rotating-priority search: rotate by ptr, take the lowest set
// bit, then un-rotate the winner's index back into requester numbering.
module rr_pick8
  import rr_arbiter8_pkg::*;
(
  input  logic [ARB_N-1:0]     req_i,
  input  logic [ARB_IDX_W-1:0] ptr_i,
  output logic [ARB_N-1:0]     gnt_o,
  output logic [ARB_IDX_W-1:0] idx_o,
  output logic                 any_o
);

  logic [2*ARB_N-1:0]   dbl;
  logic [ARB_N-1:0]     rot;
  logic [ARB_IDX_W-1:0] rot_idx;

  always_comb begin
    dbl     = {req_i, req_i} >> ptr_i;
    rot     = dbl[ARB_N-1:0];
    rot_idx = '0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (rot[i]) rot_idx = ARB_IDX_W'(i);
    end
    any_o = |req_i;
    idx_o = rot_idx + ptr_i;
    gnt_o = any_o ? (ARB_N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter: grant is held until done or request drop.
// Define RR_ARBITER8_TIMEOUT_EN to force release after MAX_HOLD cycles.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
`ifdef RR_ARBITER8_TIMEOUT_EN
#(
  parameter int MAX_HOLD = 16
)
`endif
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ARB_N-1:0]     req_i,
  input  logic                 done_i,
  output logic [ARB_N-1:0]     gnt_o,
  output logic [ARB_IDX_W-1:0] gnt_idx_o,
  output logic                 gnt_valid_o,
  output logic                 timeout_o,
  output arb_state_e           dbg_state_o
);

  arb_state_e           state_q, state_d;
  logic [ARB_IDX_W-1:0] ptr_q, ptr_d;
  logic [ARB_N-1:0]     gnt_q, gnt_d;
  logic [ARB_IDX_W-1:0] idx_q, idx_d;
  logic                 valid_q, valid_d;

  logic [ARB_N-1:0]     pick_gnt;
  logic [ARB_IDX_W-1:0] pick_idx;
  logic                 pick_any;
  logic                 normal_rel;
  logic                 force_rel;
  logic                 release_now;

  rr_pick8 u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign normal_rel  = done_i | ~req_i[idx_q];
  assign release_now = normal_rel | force_rel;

`ifdef RR_ARBITER8_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  // A normal release on the same edge wins, so timeout only fires alone.
  assign force_rel = (state_q == ST_GRANT) && (hold_q == HOLD_LAST) && !normal_rel;

  always_comb begin
    hold_d    = (state_q == ST_GRANT) ? hold_q + 8'd1 : 8'd0;
    timeout_d = force_rel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_any)    state_d = ST_GRANT;
      ST_GRANT: if (release_now) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          valid_d = 1'b1;
        end
      end
      ST_GRANT: begin
        // The holder drops to lowest priority for the next search.
        if (release_now) begin
          gnt_d   = '0;
          valid_d = 1'b0;
          ptr_d   = idx_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = valid_q;
  assign dbg_state_o = state_q;

endmodule
